// File: rtl/mask_stats_pkg.sv
// Shared definitions for mask_blob_stats: register map, FSM states, ID and widths.
package mask_stats_pkg;

  localparam int COORD_W = 11;
  localparam int COUNT_W = 19;
  localparam int SUM_W   = 28;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_COUNT  = 3'd1;
  localparam logic [2:0] ADDR_SUM_X  = 3'd2;
  localparam logic [2:0] ADDR_SUM_Y  = 3'd3;
  localparam logic [2:0] ADDR_BB_TL  = 3'd4;
  localparam logic [2:0] ADDR_BB_BR  = 3'd5;
  localparam logic [2:0] ADDR_ID     = 3'd6;
  localparam logic [2:0] ADDR_CTRL   = 3'd7;

  localparam logic [31:0] ID_VALUE = 32'h1234EEE3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VIDEO = 2'd1,
    ST_SKIP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COUNT_W-1:0] count;
    logic [SUM_W-1:0]   sum_x;
    logic [SUM_W-1:0]   sum_y;
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
  } stats_t;

endpackage

// File: rtl/mask_stats_accum.sv
// Pixel x/y tracking and per-frame hit accumulators. stats_next already
// includes the current beat, so an eop pixel can be latched in its own cycle.
module mask_stats_accum
  import mask_stats_pkg::*;
#(
  parameter logic [COORD_W-1:0] IMAGE_W = 11'd640,
  parameter logic [COORD_W-1:0] IMAGE_H = 11'd480
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   clear,
  input  logic   pixel_en,
  input  logic   pixel_bit,
  output stats_t stats_next
);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  stats_t             stats_q;
  stats_t             stats_init;
  logic               hit;

  assign hit = pixel_en & pixel_bit & (y_q < IMAGE_H);

  always_comb begin
    stats_init       = '0;
    stats_init.x_min = IMAGE_W - COORD_W'(1);
    stats_init.y_min = IMAGE_H - COORD_W'(1);
  end

  always_comb begin
    stats_next = stats_q;
    if (hit) begin
      stats_next.count = stats_q.count + COUNT_W'(1);
      stats_next.sum_x = stats_q.sum_x + {{(SUM_W-COORD_W){1'b0}}, x_q};
      stats_next.sum_y = stats_q.sum_y + {{(SUM_W-COORD_W){1'b0}}, y_q};
      if (x_q < stats_q.x_min) stats_next.x_min = x_q;
      if (x_q > stats_q.x_max) stats_next.x_max = x_q;
      if (y_q < stats_q.y_min) stats_next.y_min = y_q;
      if (y_q > stats_q.y_max) stats_next.y_max = y_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      stats_q <= '0;
    end else if (clear) begin
      x_q     <= '0;
      y_q     <= '0;
      stats_q <= stats_init;
    end else if (pixel_en) begin
      stats_q <= stats_next;
      if (x_q == IMAGE_W - COORD_W'(1)) begin
        x_q <= '0;
        // y saturates so an overlong frame never wraps back into the image
        if (y_q != '1) y_q <= y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/mask_blob_stats.sv
// Blob statistics over a masked video stream with an MM register interface.
// Optional build macro MASK_STATS_IRQ_EN adds a registered irq output.
// Stream handshake: a beat transfers when sink_valid & sink_ready; the stream
// is a zero-latency wire-through, so sink_ready simply mirrors source_ready.
module mask_blob_stats
  import mask_stats_pkg::*;
#(
  parameter logic [COORD_W-1:0] IMAGE_W    = 11'd640,
  parameter logic [COORD_W-1:0] IMAGE_H    = 11'd480,
  parameter logic [COUNT_W-1:0] MIN_PIXELS = 19'd16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        source_ready,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata
`ifdef MASK_STATS_IRQ_EN
  ,
  output logic        irq
`endif
);

  state_t      state_q;
  stats_t      acc_next;
  stats_t      res_q;
  logic        valid_q;
  logic        found_q;
  logic        overrun_q;
  logic [7:0]  frame_cnt_q;
  logic        enable_q;
  logic        irq_en_q;
  logic        accept;
  logic        sop_go;
  logic        pixel_beat;
  logic        pixel_en;
  logic        latch;
  logic        skip_end;
  logic        wr_status;
  logic        wr_ctrl;
  logic [31:0] rd_mux;
  logic [28:0] unused_wdata;

  assign source_data  = sink_data;
  assign source_valid = sink_valid;
  assign source_sop   = sink_sop;
  assign source_eop   = sink_eop;
  assign sink_ready   = source_ready;

  assign accept     = sink_valid & source_ready;
  assign sop_go     = accept & sink_sop & enable_q;
  // With enable low, sop beats are dropped entirely rather than seen as pixels
  assign pixel_beat = accept & ~sink_sop;
  assign pixel_en   = pixel_beat & (state_q == ST_VIDEO);
  assign latch      = pixel_en & sink_eop;
  assign skip_end   = pixel_beat & sink_eop & (state_q == ST_SKIP);
  assign wr_status  = s_chipselect & s_write & (s_address == ADDR_STATUS);
  assign wr_ctrl    = s_chipselect & s_write & (s_address == ADDR_CTRL);
  assign unused_wdata = s_writedata[31:3];

  mask_stats_accum #(
    .IMAGE_W (IMAGE_W),
    .IMAGE_H (IMAGE_H)
  ) u_accum (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (sop_go),
    .pixel_en   (pixel_en),
    .pixel_bit  (sink_data[23]),
    .stats_next (acc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else if (sop_go) begin
      state_q <= (sink_data[3:0] == 4'h0) ? ST_VIDEO : ST_SKIP;
    end else if (latch || skip_end) begin
      state_q <= ST_IDLE;
    end
  end

  // Result latch takes priority over a software clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q       <= '0;
      valid_q     <= 1'b0;
      found_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else if (latch) begin
      res_q       <= acc_next;
      valid_q     <= 1'b1;
      found_q     <= (acc_next.count >= MIN_PIXELS);
      overrun_q   <= overrun_q | valid_q;
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end else if (wr_status) begin
      if (s_writedata[0]) valid_q   <= 1'b0;
      if (s_writedata[2]) overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b1;
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      enable_q <= s_writedata[0];
`ifdef MASK_STATS_IRQ_EN
      irq_en_q <= s_writedata[1];
`endif
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      ADDR_STATUS: rd_mux = {16'b0, frame_cnt_q, 5'b0, overrun_q, found_q, valid_q};
      ADDR_COUNT:  rd_mux = {{(32-COUNT_W){1'b0}}, res_q.count};
      ADDR_SUM_X:  rd_mux = {{(32-SUM_W){1'b0}}, res_q.sum_x};
      ADDR_SUM_Y:  rd_mux = {{(32-SUM_W){1'b0}}, res_q.sum_y};
      ADDR_BB_TL:  rd_mux = {5'b0, res_q.x_min, 5'b0, res_q.y_min};
      ADDR_BB_BR:  rd_mux = {5'b0, res_q.x_max, 5'b0, res_q.y_max};
      ADDR_ID:     rd_mux = ID_VALUE;
      ADDR_CTRL:   rd_mux = {30'b0, irq_en_q, enable_q};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= '0;
    end else if (s_chipselect && s_read) begin
      s_readdata <= rd_mux;
    end
  end

`ifdef MASK_STATS_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= valid_q & irq_en_q;
    end
  end
`endif

endmodule

// File: doc/mask_blob_stats.md
MASK_BLOB_STATS -- requirements
Module: mask_blob_stats

Interface
REQ-001 Parameter IMAGE_W, 11'd640, pixels per line.
REQ-002 Parameter IMAGE_H, 11'd480, lines per frame.
REQ-003 Parameter MIN_PIXELS, 19'd16, minimum hit count for "object found".
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sink_data/sink_valid/sink_sop/sink_eop  in  24/1/1/1  masked video stream from the image-processing stage; sink_ready  out  1.
REQ-007 source_data/source_valid/source_sop/source_eop  out  24/1/1/1  pass-through stream; source_ready  in  1.
REQ-008 s_chipselect, s_read, s_write  in  1 each; s_address  in  3; s_writedata  in  32; s_readdata  out  32  MM slave.

Function
REQ-009 Stream path is combinational pass-through with zero latency: source_* = sink_*, sink_ready = source_ready.
REQ-010 Beat accepted only when sink_valid & sink_ready; stalled cycles change no state.
REQ-011 FSM states: IDLE, VIDEO, SKIP. Accepted sop beat with data[3:0]==0 goes to VIDEO; any other sop beat goes to SKIP.
REQ-012 The sop beat is a descriptor, not a pixel; x,y (11-bit) clear on it.
REQ-013 In VIDEO, each accepted non-sop beat is pixel (x,y): x increments, wraps IMAGE_W-1 -> 0 with y+1.
REQ-014 Pixel is a hit when sink_data[23]==1 and y < IMAGE_H; pixels with y >= IMAGE_H are ignored.
REQ-015 Per hit: count += 1 (19-bit); sum_x += x (28-bit); sum_y += y (28-bit); x_min, x_max, y_min, y_max updated.
REQ-016 On VIDEO entry: count/sums = 0, x_min = IMAGE_W-1, y_min = IMAGE_H-1, x_max = y_max = 0.
REQ-017 Accepted eop in VIDEO latches all accumulators into result registers in the same cycle. The eop beat is itself counted if it is a hit.
REQ-018 On that latch: found = (count >= MIN_PIXELS), valid = 1, frame_cnt (8-bit) += 1 with wrap. If valid was already 1, overrun (sticky) = 1.
REQ-019 After eop: VIDEO -> IDLE, SKIP -> IDLE. A sop beat in VIDEO discards the partial frame without latching and re-enters VIDEO or SKIP.
REQ-020 When CTRL.enable == 0, sop beats are ignored (FSM stays in IDLE) and streaming is unaffected.
REQ-021 Register map (32-bit, unused bits read 0):
  0 STATUS {frame_cnt[15:8], overrun[2], found[1], valid[0]}
  1 COUNT
  2 SUM_X
  3 SUM_Y
  4 BB_TL {5'b0, x_min, 5'b0, y_min}
  5 BB_BR {5'b0, x_max, 5'b0, y_max}
  6 ID 32'h1234EEE3
  7 CTRL {irq_en[1], enable[0]}
REQ-022 Reads are registered: s_readdata is valid the cycle after s_chipselect & s_read.
REQ-023 Writing STATUS with bit0=1 clears valid; with bit2=1 clears overrun. A result latch in the same cycle wins: valid and overrun are set.
REQ-024 CTRL is R/W; the other registers ignore writes.

Reset
REQ-025 reset_n low asynchronously clears: FSM to IDLE, x, y, accumulators, result registers, valid, found, overrun, frame_cnt, s_readdata, irq_en. enable is set to 1.
REQ-026 Reset mid-frame discards the partial frame; accumulation restarts at the next video sop.

Configuration
REQ-027 Macro MASK_STATS_IRQ_EN defined: output irq (1 bit) = valid & irq_en, registered.
REQ-028 MASK_STATS_IRQ_EN undefined: no irq port; CTRL[1] is not writable and reads 0.

Structure
REQ-029 Shared package mask_stats_pkg holds the register address constants, the FSM state enumeration, the ID value and the accumulator widths.
REQ-030 One sub-module, mask_stats_accum, implements the x/y counters and per-frame accumulators; the top level holds the FSM, result registers and MM slave.

Verification
REQ-031 Video frame of 640x480 with hits only at (10,20) and (100,200) -> COUNT=2, SUM_X=110, SUM_Y=220, BB_TL=0x000A0014, BB_BR=0x006400C8, found=0.
REQ-032 Frame with a 5x5 hit block at x 50..54, y 60..64 -> COUNT=25, SUM_X=1300, SUM_Y=1550, found=1, STATUS.valid=1.
REQ-033 Non-video packet (sop data[3:0]=0xF) full of hits -> results, frame_cnt and valid unchanged.
REQ-034 Two frames with no STATUS clear between them -> overrun=1 and frame_cnt=2; STATUS write 0x5 in the same cycle as the third eop -> valid=1, overrun=1.
REQ-035 source_ready toggling every cycle plus random sink_valid -> source stream matches sink beat-for-beat, and results equal those of the unstalled run.
REQ-036 reset_n pulsed mid-frame, then a full frame -> results reflect only the post-reset frame; STATUS=0 immediately after reset.
